keypad_event_queue: RTL

Downstream of the 16-key debounce filter: takes its one-cycle-per-press `key_pulse[15:0]` vector and turns it into a strictly ordered queue of 4-bit key codes that the Cortex-M0 peripheral wrapper pops.
- Presses on several keys in the same cycle are all captured and serialised lowest key index first.
- Events lost to back-pressure are flagged in a sticky overflow bit.
- A level interrupt is raised whenever the queue holds events or overflow is set.

---
 rtl/keypad_event_queue.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/keypad_event_queue.sv
`default_nettype none
// ============================================================================
// Module   : keypad_event_queue
// Purpose  : Turns one-cycle key press pulses from the 16-key debounce filter
//            into an ordered queue of 4-bit key codes. Keys pressed together
//            in one cycle are serialised lowest index first. A press that
//            arrives while the previous press of the same key is still
//            waiting to be queued sets a sticky overflow flag. The level
//            interrupt is raised while the queue is non-empty or overflow is
//            set.
// Ports    : clk        - rising-edge clock
//            rstn       - asynchronous active-low reset
//            key_pulse  - press pulses, bit k = key k
//            evt_ready  - consumer pops the head event this cycle
//            ovf_clr    - one-cycle clear of the overflow flag
//            evt_valid  - queue non-empty, head event presented
//            evt_code   - key index of the head event (show-ahead)
//            evt_count  - number of queued entries, 0..DEPTH
//            ovf        - sticky overflow flag
//            irq        - evt_valid | ovf
// Revision : 1.0 - initial release
// ============================================================================
module keypad_event_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [15:0]   key_pulse,
  input  logic          evt_ready,
  input  logic          ovf_clr,
  output logic          evt_valid,
  output logic [3:0]    evt_code,
  output logic [AW:0]   evt_count,
  output logic          ovf,
  output logic          irq
);

  localparam logic [AW:0]   c_depth   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_cnt_one = (AW+1)'(1);
  localparam logic [AW-1:0] c_ptr_one = AW'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [15:0]   r_pend;
  logic [3:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_ovf;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic [15:0] w_lowest;
  logic [15:0] w_grant;
  logic [15:0] w_pend_next;
  logic [3:0]  w_code;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_ovf_set;

  // Two's-complement trick isolates the lowest set pending bit.
  assign w_lowest = r_pend & (~r_pend + 16'd1);

  assign w_full = (r_count == c_depth);
  assign w_pop  = evt_valid & evt_ready;
  // A full queue can still accept a push when the head leaves in the same
  // cycle, so the count stays at DEPTH instead of stalling a cycle.
  assign w_push = (|r_pend) & (~w_full | w_pop);

  assign w_grant = w_push ? w_lowest : 16'd0;

  // A press coinciding with the grant of the same key re-arms the pending
  // bit as a fresh event; only a press onto a still-waiting bit is lost.
  assign w_pend_next = (r_pend & ~w_grant) | key_pulse;
  assign w_ovf_set   = |(key_pulse & r_pend & ~w_grant);

  // One-hot to index encoder; w_lowest has at most one bit set.
  always_comb begin
    w_code = 4'd0;
    for (int k = 0; k < 16; k++) begin
      if (w_lowest[k]) begin
        w_code = 4'(k);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pending register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend <= 16'd0;
    end else begin
      r_pend <= w_pend_next;
    end
  end

  // --------------------------------------------------------------------------
  // Storage and pointers. Storage is cleared on reset so evt_code reads 0
  // out of reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 4'd0;
      end
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_code;
      r_wr_ptr        <= r_wr_ptr + c_ptr_one;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_ptr <= '0;
    end else if (w_pop) begin
      r_rd_ptr <= r_rd_ptr + c_ptr_one;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sticky overflow: a new loss in the clearing cycle keeps the flag set.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs, all derived from registers only
  // --------------------------------------------------------------------------
  assign evt_valid = (r_count != '0);
  assign evt_code  = r_mem[r_rd_ptr];
  assign evt_count = r_count;
  assign ovf       = r_ovf;
  assign irq       = evt_valid | r_ovf;

endmodule
`default_nettype wire
